jtag_ctap_bridge: RTL and testbench

//  Parametrised successor JTAG front end. Integrates its own IEEE 1149.1 16-state TAP FSM, IR, BYPASS and IDCODE.

---
 rtl/jtag_ctap_bridge_pkg.sv | 90 +++++++++
 rtl/jtag_ctap_bridge_if.sv | 56 +++++
 rtl/jtag_bridge_tap_fsm.sv | 37 +++
 rtl/jtag_ctap_bridge.sv | 189 ++++++++++++++++++
 tb/tb_jtag_ctap_bridge.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/jtag_ctap_bridge_pkg.sv
// Shared definitions for the JTAG-to-CTAP bridge: TAP state encodings,
// TAP state decode struct, parameter defaults and small helpers.
// Optional IRQ support in the bridge is enabled by JTAG_BRIDGE_IRQ_EN.
package jtag_ctap_bridge_pkg;

  localparam int          DEF_DATA_W      = 64;
  localparam int          DEF_NUM_REGS    = 4;
  localparam int          DEF_IR_W        = 6;
  localparam logic [5:0]  DEF_IR_REG_BASE = 6'h20;
  localparam logic [5:0]  DEF_IR_IDCODE   = 6'h01;
  localparam logic [5:0]  DEF_IR_IRQ      = 6'h1F;
  localparam int          DEF_NUM_IRQ     = 8;
  localparam logic [31:0] DEF_IDCODE_VAL  = 32'h0000_0001;

  // IEEE 1149.1 conventional 4-bit TAP state encodings.
  typedef enum logic [3:0] {
    TAP_EXIT2_DR   = 4'h0,
    TAP_EXIT1_DR   = 4'h1,
    TAP_SHIFT_DR   = 4'h2,
    TAP_PAUSE_DR   = 4'h3,
    TAP_SELECT_IR  = 4'h4,
    TAP_UPDATE_DR  = 4'h5,
    TAP_CAPTURE_DR = 4'h6,
    TAP_SELECT_DR  = 4'h7,
    TAP_EXIT2_IR   = 4'h8,
    TAP_EXIT1_IR   = 4'h9,
    TAP_SHIFT_IR   = 4'hA,
    TAP_PAUSE_IR   = 4'hB,
    TAP_RUN_IDLE   = 4'hC,
    TAP_UPDATE_IR  = 4'hD,
    TAP_CAPTURE_IR = 4'hE,
    TAP_RESET      = 4'hF
  } tap_state_t;

  // One-hot decode of the states the datapath acts on.
  typedef struct packed {
    logic tlr;
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
  } tap_dec_t;

  // Register-select width; a single register still gets a 1-bit select.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // TMS-driven successor of a TAP state.
  function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
    tap_state_t n;
    n = s;
    case (s)
      TAP_RESET:      n = tms ? TAP_RESET     : TAP_RUN_IDLE;
      TAP_RUN_IDLE:   n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_DR:  n = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
      TAP_CAPTURE_DR: n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_SHIFT_DR:   n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
      TAP_EXIT1_DR:   n = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
      TAP_PAUSE_DR:   n = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
      TAP_EXIT2_DR:   n = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
      TAP_UPDATE_DR:  n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      TAP_SELECT_IR:  n = tms ? TAP_RESET     : TAP_CAPTURE_IR;
      TAP_CAPTURE_IR: n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_SHIFT_IR:   n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
      TAP_EXIT1_IR:   n = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
      TAP_PAUSE_IR:   n = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
      TAP_EXIT2_IR:   n = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
      TAP_UPDATE_IR:  n = tms ? TAP_SELECT_DR : TAP_RUN_IDLE;
      default:        n = TAP_RESET;
    endcase
    return n;
  endfunction

  function automatic tap_dec_t tap_decode(input tap_state_t s);
    tap_dec_t d;
    d            = '0;
    d.tlr        = (s == TAP_RESET);
    d.capture_dr = (s == TAP_CAPTURE_DR);
    d.shift_dr   = (s == TAP_SHIFT_DR);
    d.update_dr  = (s == TAP_UPDATE_DR);
    d.capture_ir = (s == TAP_CAPTURE_IR);
    d.shift_ir   = (s == TAP_SHIFT_IR);
    d.update_ir  = (s == TAP_UPDATE_IR);
    return d;
  endfunction

endpackage

// File: rtl/jtag_ctap_bridge_if.sv
// Pad/CTAP-side signal bundle of the JTAG-to-CTAP bridge.
// The IRQ source vector exists only when JTAG_BRIDGE_IRQ_EN is defined.
//
// Write strobe protocol: jtag_ctap_reg_wr_en is a single-cycle qualifier with
// no backpressure. While it is high, jtag_ctap_data and jtag_ctap_reg_sel are
// stable and valid, and the CTAP must accept the write in that cycle.
interface jtag_ctap_bridge_if
  import jtag_ctap_bridge_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_REGS = DEF_NUM_REGS
`ifdef JTAG_BRIDGE_IRQ_EN
  , parameter int NUM_IRQ = DEF_NUM_IRQ
`endif
);

  localparam int SEL_W = sel_width(NUM_REGS);

  logic              jtag_modesel;
  logic              jtag_datain;
  logic              jtag_dataout;
  logic              jtag_dataout_en;
  logic [DATA_W-1:0] ctap_jtag_data;
  logic [DATA_W-1:0] jtag_ctap_data;
  logic              jtag_ctap_reg_wr_en;
  logic [SEL_W-1:0]  jtag_ctap_reg_sel;
  tap_state_t        dbg_tap_state;
`ifdef JTAG_BRIDGE_IRQ_EN
  logic [NUM_IRQ-1:0] ctap_jtag_irq;

  modport master (
    output jtag_modesel, jtag_datain, ctap_jtag_data, ctap_jtag_irq,
    input  jtag_dataout, jtag_dataout_en, jtag_ctap_data,
           jtag_ctap_reg_wr_en, jtag_ctap_reg_sel, dbg_tap_state
  );

  modport slave (
    input  jtag_modesel, jtag_datain, ctap_jtag_data, ctap_jtag_irq,
    output jtag_dataout, jtag_dataout_en, jtag_ctap_data,
           jtag_ctap_reg_wr_en, jtag_ctap_reg_sel, dbg_tap_state
  );
`else
  modport master (
    output jtag_modesel, jtag_datain, ctap_jtag_data,
    input  jtag_dataout, jtag_dataout_en, jtag_ctap_data,
           jtag_ctap_reg_wr_en, jtag_ctap_reg_sel, dbg_tap_state
  );

  modport slave (
    input  jtag_modesel, jtag_datain, ctap_jtag_data,
    output jtag_dataout, jtag_dataout_en, jtag_ctap_data,
           jtag_ctap_reg_wr_en, jtag_ctap_reg_sel, dbg_tap_state
  );
`endif

endinterface

// File: rtl/jtag_bridge_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller. The state register and the one-hot
// decode of the datapath-relevant states are both registered, so the decode
// flags are glitch-free and aligned with the state they describe.
module jtag_bridge_tap_fsm
  import jtag_ctap_bridge_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tms,
  output tap_state_t state_o,
  output tap_dec_t   dec_o
);

  tap_state_t state_q, state_d;
  tap_dec_t   dec_q, dec_d;

  // Next state from TMS, plus the decode of that next state.
  always_comb begin
    state_d = tap_next(state_q, tms);
    dec_d   = tap_decode(state_d);
  end

  // State and decode registers; reset parks the TAP in Test-Logic-Reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= TAP_RESET;
      dec_q   <= tap_decode(TAP_RESET);
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
    end
  end

  assign state_o = state_q;
  assign dec_o   = dec_q;

endmodule

// File: rtl/jtag_ctap_bridge.sv
// JTAG front end bridging chip pads to the CTAP: TAP controller, IR,
// IDCODE, BYPASS and a shared DATA_W-bit CTAP shift register that serves
// NUM_REGS selectable CTAP registers.
// Define JTAG_BRIDGE_IRQ_EN to add the sticky W1C IRQ status register
// reachable through IR_IRQ; without it IR_IRQ decodes to BYPASS.
module jtag_ctap_bridge
  import jtag_ctap_bridge_pkg::*;
#(
  parameter int              DATA_W      = DEF_DATA_W,
  parameter int              NUM_REGS    = DEF_NUM_REGS,
  parameter int              IR_W        = DEF_IR_W,
  parameter logic [IR_W-1:0] IR_REG_BASE = IR_W'(DEF_IR_REG_BASE),
  parameter logic [IR_W-1:0] IR_IDCODE   = IR_W'(DEF_IR_IDCODE),
`ifdef JTAG_BRIDGE_IRQ_EN
  parameter logic [IR_W-1:0] IR_IRQ      = IR_W'(DEF_IR_IRQ),
  parameter int              NUM_IRQ     = DEF_NUM_IRQ,
`endif
  parameter logic [31:0]     IDCODE_VAL  = DEF_IDCODE_VAL
) (
  input logic               jtag_clk,
  input logic               jtag_rst,
  jtag_ctap_bridge_if.slave bus
);

  localparam int          SEL_W  = sel_width(NUM_REGS);
  localparam logic [31:0] REG_LO = 32'(IR_REG_BASE);
  localparam logic [31:0] REG_HI = REG_LO + 32'(NUM_REGS);

  tap_state_t tap_state;
  tap_dec_t   dec;

  logic [IR_W-1:0]   ir_q, ir_d;
  logic [IR_W-1:0]   ir_sr_q, ir_sr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] ctap_sr_q, ctap_sr_d;
  logic [31:0]       id_sr_q, id_sr_d;
  logic              byp_q, byp_d;
  logic              tdo_q, tdo_d;
  logic              tdo_en_q, tdo_en_d;
  logic              dr_ctap, dr_idcode, ir_sr_ctap;
  logic              tdi;
`ifdef JTAG_BRIDGE_IRQ_EN
  logic              dr_irq;
  logic [NUM_IRQ-1:0] irq_sr_q, irq_sr_d;
  logic [NUM_IRQ-1:0] irq_status_q, irq_status_d;
  logic [NUM_IRQ-1:0] irq_clr;
`endif

  assign tdi = bus.jtag_datain;

  jtag_bridge_tap_fsm u_tap_fsm (
    .clk     (jtag_clk),
    .rst     (jtag_rst),
    .tms     (bus.jtag_modesel),
    .state_o (tap_state),
    .dec_o   (dec)
  );

  // Instruction decode: CTAP window first, then IDCODE, then IRQ; the rest is BYPASS.
  always_comb begin
    dr_ctap    = (32'(ir_q) >= REG_LO) && (32'(ir_q) < REG_HI);
    dr_idcode  = !dr_ctap && (ir_q == IR_IDCODE);
    ir_sr_ctap = (32'(ir_sr_q) >= REG_LO) && (32'(ir_sr_q) < REG_HI);
`ifdef JTAG_BRIDGE_IRQ_EN
    dr_irq     = !dr_ctap && !dr_idcode && (ir_q == IR_IRQ);
`endif
  end

  // IR/DR datapath: capture, shift and update per decoded TAP state.
  always_comb begin
    ir_d      = ir_q;
    ir_sr_d   = ir_sr_q;
    sel_d     = sel_q;
    ctap_sr_d = ctap_sr_q;
    id_sr_d   = id_sr_q;
    byp_d     = byp_q;
    tdo_d     = 1'b0;
    tdo_en_d  = 1'b0;
`ifdef JTAG_BRIDGE_IRQ_EN
    irq_sr_d  = irq_sr_q;
`endif
    if (dec.tlr) begin
      ir_d      = IR_IDCODE;
      ir_sr_d   = '0;
      sel_d     = '0;
      ctap_sr_d = '0;
      id_sr_d   = '0;
      byp_d     = 1'b0;
`ifdef JTAG_BRIDGE_IRQ_EN
      irq_sr_d  = '0;
`endif
    end else begin
      if (dec.capture_ir) begin
        ir_sr_d = IR_W'(2'b01);
      end
      if (dec.shift_ir) begin
        tdo_d    = ir_sr_q[0];
        tdo_en_d = 1'b1;
        ir_sr_d  = {tdi, ir_sr_q[IR_W-1:1]};
      end
      if (dec.update_ir) begin
        ir_d = ir_sr_q;
        // The select only follows instructions that address a CTAP register.
        if (ir_sr_ctap) begin
          sel_d = SEL_W'(32'(ir_sr_q) - REG_LO);
        end
      end
      if (dec.capture_dr) begin
        if (dr_ctap) begin
          ctap_sr_d = bus.ctap_jtag_data;
        end else if (dr_idcode) begin
          id_sr_d = IDCODE_VAL;
`ifdef JTAG_BRIDGE_IRQ_EN
        end else if (dr_irq) begin
          irq_sr_d = irq_status_q;
`endif
        end else begin
          byp_d = 1'b0;
        end
      end
      if (dec.shift_dr) begin
        tdo_en_d = 1'b1;
        if (dr_ctap) begin
          // CTAP register shifts MSB-first, unlike the other DRs.
          tdo_d     = ctap_sr_q[DATA_W-1];
          ctap_sr_d = {ctap_sr_q[DATA_W-2:0], tdi};
        end else if (dr_idcode) begin
          tdo_d   = id_sr_q[0];
          id_sr_d = {tdi, id_sr_q[31:1]};
`ifdef JTAG_BRIDGE_IRQ_EN
        end else if (dr_irq) begin
          tdo_d    = irq_sr_q[0];
          irq_sr_d = {tdi, irq_sr_q[NUM_IRQ-1:1]};
`endif
        end else begin
          tdo_d = byp_q;
          byp_d = tdi;
        end
      end
    end
  end

`ifdef JTAG_BRIDGE_IRQ_EN
  // Sticky status: a new IRQ level in the same cycle beats a W1C clear.
  always_comb begin
    irq_clr      = (dec.update_dr && dr_irq) ? irq_sr_q : '0;
    irq_status_d = (irq_status_q & ~irq_clr) | bus.ctap_jtag_irq;
  end
`endif

  // Datapath registers; reset drops any partially shifted data.
  always_ff @(posedge jtag_clk) begin
    if (jtag_rst) begin
      ir_q         <= IR_IDCODE;
      ir_sr_q      <= '0;
      sel_q        <= '0;
      ctap_sr_q    <= '0;
      id_sr_q      <= '0;
      byp_q        <= 1'b0;
      tdo_q        <= 1'b0;
      tdo_en_q     <= 1'b0;
`ifdef JTAG_BRIDGE_IRQ_EN
      irq_sr_q     <= '0;
      irq_status_q <= '0;
`endif
    end else begin
      ir_q         <= ir_d;
      ir_sr_q      <= ir_sr_d;
      sel_q        <= sel_d;
      ctap_sr_q    <= ctap_sr_d;
      id_sr_q      <= id_sr_d;
      byp_q        <= byp_d;
      tdo_q        <= tdo_d;
      tdo_en_q     <= tdo_en_d;
`ifdef JTAG_BRIDGE_IRQ_EN
      irq_sr_q     <= irq_sr_d;
      irq_status_q <= irq_status_d;
`endif
    end
  end

  assign bus.jtag_dataout        = tdo_q;
  assign bus.jtag_dataout_en     = tdo_en_q;
  assign bus.jtag_ctap_data      = ctap_sr_q;
  assign bus.jtag_ctap_reg_sel   = sel_q;
  assign bus.jtag_ctap_reg_wr_en = dec.update_dr && dr_ctap;
  assign bus.dbg_tap_state       = tap_state;

endmodule

// File: tb/tb_jtag_ctap_bridge.sv
// Directed bench for jtag_ctap_bridge: IDCODE, CTAP write/read, BYPASS,
// reset mid-shift and, with JTAG_BRIDGE_IRQ_EN, the W1C IRQ status path.
module tb_jtag_ctap_bridge;
  import jtag_ctap_bridge_pkg::*;

  localparam int          DATA_W     = 64;
  localparam int          NUM_REGS   = 4;
  localparam logic [31:0] IDCODE_VAL = 32'h4BA0_0477;
  localparam logic [63:0] WR_VAL     = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] RD_VAL     = 64'hA5A5_A5A5_A5A5_A5A5;
`ifdef JTAG_BRIDGE_IRQ_EN
  localparam int          NUM_IRQ    = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  logic [0:0] exp_q[$];

  // Clock / reset block
  always #5 clk = ~clk;

  jtag_ctap_bridge_if #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
`ifdef JTAG_BRIDGE_IRQ_EN
    , .NUM_IRQ (NUM_IRQ)
`endif
  ) bus ();

  jtag_ctap_bridge #(
    .DATA_W     (DATA_W),
    .NUM_REGS   (NUM_REGS),
`ifdef JTAG_BRIDGE_IRQ_EN
    .NUM_IRQ    (NUM_IRQ),
`endif
    .IDCODE_VAL (IDCODE_VAL)
  ) dut (
    .jtag_clk (clk),
    .jtag_rst (rst),
    .bus      (bus)
  );

  // Count write strobes, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.jtag_ctap_reg_wr_en === 1'b1) wr_cnt++;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rev64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = v[63-i];
    return r;
  endfunction

  // Driver: apply TMS/TDI, clock once, settle past the edge.
  task automatic tick(input logic tms, input logic tdi);
    bus.jtag_modesel = tms;
    bus.jtag_datain  = tdi;
    @(posedge clk);
    #1;
  endtask

  task automatic goto_shift_dr();
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  task automatic goto_shift_ir();
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
  endtask

  // Shift n bits from Shift-xR (last with TMS=1); exp_v bit i is the i-th TDO bit.
  task automatic shift_bits(input string tag, input int n, input logic [63:0] tdi_v,
                            input logic [63:0] exp_v);
    logic [0:0] e;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(exp_v[i]);
      tick(i == n - 1, tdi_v[i]);
      e = exp_q.pop_front();
      check({tag, "_tdo"}, 64'(bus.jtag_dataout), 64'(e));
      check({tag, "_en"}, 64'(bus.jtag_dataout_en), 64'd1);
    end
  endtask

  // Load an instruction from Run-Test/Idle; ends back in Run-Test/Idle.
  task automatic load_ir(input logic [5:0] ir, input string tag);
    goto_shift_ir();
    shift_bits(tag, 6, 64'(ir), 64'h1);
    tick(1'b1, 1'b0);
    check({tag, "_en_off"}, 64'(bus.jtag_dataout_en), 64'd0);
    tick(1'b0, 1'b0);
  endtask

`ifdef JTAG_BRIDGE_IRQ_EN
  task automatic pulse_irq();
    bus.ctap_jtag_irq = 8'h08;
    tick(1'b0, 1'b0);
    bus.ctap_jtag_irq = '0;
  endtask

  task automatic irq_round(input string tag, input logic [7:0] exp_v,
                           input logic [7:0] tdi_v, input logic hold);
    goto_shift_dr();
    shift_bits(tag, 8, 64'(tdi_v), 64'(exp_v));
    tick(1'b1, 1'b0);
    if (hold) bus.ctap_jtag_irq = 8'h08;
    tick(1'b0, 1'b0);
    bus.ctap_jtag_irq = '0;
  endtask
`endif

  initial begin
    logic [63:0] cap_val;
    logic [63:0] tdi_v;

    bus.jtag_modesel   = 1'b1;
    bus.jtag_datain    = 1'b0;
    bus.ctap_jtag_data = '0;
`ifdef JTAG_BRIDGE_IRQ_EN
    bus.ctap_jtag_irq  = '0;
`endif

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", 64'(bus.dbg_tap_state), 64'(TAP_RESET));
    check("rst_tdo", 64'(bus.jtag_dataout), 64'd0);
    check("rst_tdo_en", 64'(bus.jtag_dataout_en), 64'd0);
    check("rst_wr_en", 64'(bus.jtag_ctap_reg_wr_en), 64'd0);
    check("rst_reg_sel", 64'(bus.jtag_ctap_reg_sel), 64'd0);
    check("rst_ctap_data", bus.jtag_ctap_data, 64'd0);
    rst = 1'b0;
    tick(1'b0, 1'b0);

    // IDCODE is the default instruction after reset
    goto_shift_dr();
    shift_bits("idcode", 32, 64'($urandom), 64'(IDCODE_VAL));
    tick(1'b1, 1'b0);
    check("idcode_en_off", 64'(bus.jtag_dataout_en), 64'd0);
    tick(1'b0, 1'b0);
    check("idcode_no_wr", 64'(wr_cnt), 64'd0);

    // CTAP write through register 2
    cap_val = {$urandom, $urandom};
    bus.ctap_jtag_data = cap_val;
    load_ir(6'h22, "ir22");
    check("wr_reg_sel", 64'(bus.jtag_ctap_reg_sel), 64'd2);
    goto_shift_dr();
    shift_bits("ctap_wr", 64, rev64(WR_VAL), rev64(cap_val));
    check("wr_no_early_strobe", 64'(wr_cnt), 64'd0);
    tick(1'b1, 1'b0);
    check("wr_strobe", 64'(bus.jtag_ctap_reg_wr_en), 64'd1);
    check("wr_data", bus.jtag_ctap_data, WR_VAL);
    check("wr_en_off", 64'(bus.jtag_dataout_en), 64'd0);
    tick(1'b0, 1'b0);
    check("wr_strobe_off", 64'(bus.jtag_ctap_reg_wr_en), 64'd0);
    check("wr_strobe_count", 64'(wr_cnt), 64'd1);
    check("wr_data_hold", bus.jtag_ctap_data, WR_VAL);

    // CTAP read through register 1
    bus.ctap_jtag_data = RD_VAL;
    load_ir(6'h21, "ir21");
    check("rd_reg_sel", 64'(bus.jtag_ctap_reg_sel), 64'd1);
    goto_shift_dr();
    tdi_v = {$urandom, $urandom};
    shift_bits("ctap_rd", 64, tdi_v, rev64(RD_VAL));
    check("rd_no_early_strobe", 64'(wr_cnt), 64'd1);
    check("rd_shifted_in", bus.jtag_ctap_data, rev64(tdi_v));
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("rd_strobe_count", 64'(wr_cnt), 64'd2);

    // BYPASS via all-ones: 0 first, then TDI delayed by one bit
    load_ir(6'h3F, "ir3f");
    check("byp_reg_sel", 64'(bus.jtag_ctap_reg_sel), 64'd1);
    goto_shift_dr();
    shift_bits("bypass", 5, 64'b01101, 64'b11010);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("byp_no_strobe", 64'(wr_cnt), 64'd2);
    check("byp_reg_sel_hold", 64'(bus.jtag_ctap_reg_sel), 64'd1);

    // jtag_rst in the middle of a CTAP Shift-DR
    load_ir(6'h23, "ir23");
    check("mid_reg_sel", 64'(bus.jtag_ctap_reg_sel), 64'd3);
    goto_shift_dr();
    for (int i = 0; i < 7; i++) tick(1'b0, 1'($urandom));
    rst = 1'b1;
    tick(1'b0, 1'b0);
    rst = 1'b0;
    check("mid_rst_state", 64'(bus.dbg_tap_state), 64'(TAP_RESET));
    check("mid_rst_tdo_en", 64'(bus.jtag_dataout_en), 64'd0);
    check("mid_rst_tdo", 64'(bus.jtag_dataout), 64'd0);
    check("mid_rst_data", bus.jtag_ctap_data, 64'd0);
    check("mid_rst_reg_sel", 64'(bus.jtag_ctap_reg_sel), 64'd0);
    check("mid_rst_no_strobe", 64'(wr_cnt), 64'd2);
    tick(1'b0, 1'b0);
    goto_shift_dr();
    shift_bits("idcode_after_rst", 32, 64'($urandom), 64'(IDCODE_VAL));
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("idcode_after_rst_no_wr", 64'(wr_cnt), 64'd2);

    // Five TMS=1 from the middle of Shift-DR reach Test-Logic-Reset
    goto_shift_dr();
    for (int i = 0; i < 4; i++) tick(1'b0, 1'($urandom));
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
    check("tms_rst_state", 64'(bus.dbg_tap_state), 64'(TAP_RESET));
    check("tms_rst_tdo_en", 64'(bus.jtag_dataout_en), 64'd0);
    check("tms_rst_tdo", 64'(bus.jtag_dataout), 64'd0);
    check("tms_rst_no_strobe", 64'(wr_cnt), 64'd2);
    tick(1'b0, 1'b0);

`ifdef JTAG_BRIDGE_IRQ_EN
    // Sticky W1C IRQ status
    pulse_irq();
    load_ir(6'h1F, "ir1f");
    irq_round("irq_cap", 8'h08, 8'h08, 1'b0);
    irq_round("irq_cleared", 8'h00, 8'h00, 1'b0);
    pulse_irq();
    irq_round("irq_recap", 8'h08, 8'h08, 1'b1);
    irq_round("irq_set_wins", 8'h08, 8'h08, 1'b0);
    irq_round("irq_cleared2", 8'h00, 8'h00, 1'b0);
    check("irq_no_strobe", 64'(wr_cnt), 64'd2);
`else
    // Without IRQ support the IRQ opcode is plain BYPASS
    load_ir(6'h1F, "ir1f");
    goto_shift_dr();
    shift_bits("irq_op_bypass", 5, 64'b01101, 64'b11010);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    check("irq_op_no_strobe", 64'(wr_cnt), 64'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
